manchester_tx_ctrl: RTL
=======================

// Module: manchester_tx_ctrl
// PURPOSE
//  Frame controller in front of the Manchester line encoder. Accepts DATA_W-bit words over a valid/ready handshake.
//  Per frame: sends an alternating preamble, then the word MSB-first, then a fixed idle gap.
//  Sequences the half-bit timing and drives the NRZ bit to the encoder, plus a Manchester-coded line output.
//  Sits between the byte-level TX path and the line driver.
// PARAMETERS
//  DATA_W        8  payload bits per frame (>=1)
//  PREAMBLE_LEN  4  preamble bits, pattern 1,0,1,0,... starting with 1 (>=1)
//  CLKS_PER_HALF 2  clk cycles per half-bit (>=1); one bit = 2*CLKS_PER_HALF cycles
//  IDLE_LEVEL    0  line_out level when not sending a bit
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  tx_data    in   DATA_W  payload, sampled on the accept edge only
//  tx_valid   in   1       upstream has a word
//  tx_ready   out  1       controller can accept; high only in IDLE
//  nrz_bit    out  1       current bit (preamble or data) to encoder; 0 outside PRE/DATA
//  half       out  1       0 = first half-bit, 1 = second half-bit; 0 outside PRE/DATA
//  line_out   out  1       Manchester line: bit 1 -> 1 then 0; bit 0 -> 0 then 1
//  line_oe    out  1       driver enable; high in PRE, DATA and GAP
//  busy       out  1       high in any state except IDLE
//  frame_done out  1       one-cycle pulse on the last cycle of GAP
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//   - state=IDLE, counters=0.
//   - tx_ready=1, nrz_bit=0, half=0, line_out=IDLE_LEVEL, line_oe=0, busy=0, frame_done=0.
//   - Frame in flight is dropped. No partial gap.
//  All outputs are registered or decoded from registered state only. No combinational path from tx_valid/tx_data.
//  Accept:
//   - tx_valid & tx_ready at posedge k latches tx_data into the shift register; state -> PRE.
//   - First preamble half-bit is on line_out from cycle k+1 (1-cycle latency).
//   - tx_valid without tx_ready is ignored. Upstream holds it; no word is lost.
//  States:
//   - IDLE -> PRE on accept.
//   - PRE: PREAMBLE_LEN bits; bit i = ~i[0].
//   - PRE -> DATA after the last half of preamble bit PREAMBLE_LEN-1.
//   - DATA: DATA_W bits, MSB first.
//   - DATA -> GAP after the last half of bit 0.
//   - GAP: 2*CLKS_PER_HALF cycles; line_out=IDLE_LEVEL, line_oe=1.
//   - GAP -> IDLE after the gap; frame_done asserted in the final GAP cycle.
//   - tx_ready rises the cycle after frame_done. Minimum frame period = 1 + (PREAMBLE_LEN+DATA_W+1)*2*CLKS_PER_HALF cycles.
//  Timing counters:
//   - half_cnt 0..CLKS_PER_HALF-1 wraps and toggles half.
//   - half 1->0 wrap advances bit_cnt.
//   - bit_cnt is sized $clog2(max(PREAMBLE_LEN,DATA_W)+1) and reloads to 0 on each PRE->DATA and DATA->GAP transition.
//  line_out = nrz_bit ^ half in PRE/DATA; IDLE_LEVEL otherwise.
//  Illegal state encoding -> IDLE on the next edge, outputs as reset.
// STRUCTURE
//  Package manchester_pkg:
//   - typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} mtx_state_t.
//   - function manchester_level(bit, half).
//   - localparam PREAMBLE_FIRST = 1'b1.
//  Sub-module manchester_bit_timer (CLKS_PER_HALF): en, clear -> half, bit_tick.
//   - Instantiated once. Owns half_cnt and the half flag.
//  Controller holds the FSM, bit_cnt and the DATA_W shift register.
// TESTING (DATA_W=8, PREAMBLE_LEN=2, CLKS_PER_HALF=1, IDLE_LEVEL=0 unless stated)
//  1 Reset: assert rst mid-cycle, no clk edge -> all outputs at reset values immediately.
//  2 Single frame: accept 8'hA5 at edge k.
//   - line_out from k+1 = 1,0,0,1 | 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0.
//   - Then 0,0 with line_oe=1; frame_done in cycle k+22; tx_ready=1 at k+23.
//  3 Back-to-back: tx_valid held high with 8'hFF then 8'h00.
//   - Second accept exactly one cycle after the first frame_done.
//   - Data sections read 10x8 then 01x8.
//  4 Backpressure: tx_valid pulses while busy -> ignored; tx_data changing mid-frame does not alter line_out.
//  5 Reset mid-DATA: assert rst at bit 3.
//   - line_oe=0 and tx_ready=1 at once; no frame_done.
//   - Next frame 8'h3C is sent complete and correct.
//  6 CLKS_PER_HALF=3, PREAMBLE_LEN=1:
//   - each line level holds 3 cycles;
//   - frame length (1+8+1)*6 = 60 cycles from k+1 to frame_done inclusive.

Source files
------------

// File: rtl/manchester_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | manchester_pkg : shared types and helpers for the Manchester TX    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } mtx_state_t;

  localparam logic PREAMBLE_FIRST = 1'b1;

  // Bit 1 is sent high-then-low, bit 0 low-then-high.
  function automatic logic manchester_level(input logic bit_i, input logic half_i);
    return bit_i ^ half_i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_bit_timer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | manchester_bit_timer : half-bit sequencer, emits bit_tick on the   |
// | final cycle of each bit. Rev 1.0                                   |
// +-------------------------------------------------------------------+
module manchester_bit_timer #(
  parameter int CLKS_PER_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic half_o,
  output logic bit_tick_o
);

  localparam int c_CW = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_HALF - 1);

  logic [c_CW-1:0] half_cnt_q, half_cnt_d;
  logic            half_q, half_d;
  logic            w_wrap;

  assign w_wrap     = en_i && (half_cnt_q == c_LAST);
  assign bit_tick_o = w_wrap && half_q;
  assign half_o     = half_q;

  always_comb begin
    half_cnt_d = half_cnt_q;
    half_d     = half_q;
    if (clear_i) begin
      half_cnt_d = '0;
      half_d     = 1'b0;
    end else if (en_i) begin
      if (w_wrap) begin
        half_cnt_d = '0;
        half_d     = ~half_q;
      end else begin
        half_cnt_d = half_cnt_q + c_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt_q <= '0;
      half_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      half_q     <= half_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/manchester_tx_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | manchester_tx_ctrl : frames words as preamble + MSB-first data +   |
// | idle gap and drives NRZ and Manchester line outputs. Rev 1.0       |
// +-------------------------------------------------------------------+
module manchester_tx_ctrl
  import manchester_pkg::*;
#(
  parameter int   DATA_W        = 8,
  parameter int   PREAMBLE_LEN  = 4,
  parameter int   CLKS_PER_HALF = 2,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              nrz_bit_o,
  output logic              half_o,
  output logic              line_out_o,
  output logic              line_oe_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int c_MAXB = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int c_BW   = $clog2(c_MAXB + 1);
  localparam logic [c_BW-1:0] c_PRE_LAST  = c_BW'(PREAMBLE_LEN - 1);
  localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_W - 1);

  mtx_state_t        state_q;
  logic [c_BW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;

  logic w_half, w_bit_tick, w_sending, w_nrz;

  // Timer is held cleared in IDLE so every frame starts on a fresh first half.
  manchester_bit_timer #(
    .CLKS_PER_HALF(CLKS_PER_HALF)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != IDLE),
    .clear_i   (state_q == IDLE),
    .half_o    (w_half),
    .bit_tick_o(w_bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid_i) begin
            shreg_q   <= tx_data_i;
            bit_cnt_q <= '0;
            state_q   <= PRE;
          end
        end
        PRE: begin
          if (w_bit_tick) begin
            if (bit_cnt_q == c_PRE_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + c_BW'(1);
            end
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            shreg_q <= shreg_q << 1;
            if (bit_cnt_q == c_DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              bit_cnt_q <= bit_cnt_q + c_BW'(1);
            end
          end
        end
        GAP: begin
          if (w_bit_tick) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign w_sending = (state_q == PRE) || (state_q == DATA);
  assign w_nrz     = (state_q == PRE) ? (PREAMBLE_FIRST ^ bit_cnt_q[0])
                                      : shreg_q[DATA_W-1];

  assign tx_ready_o   = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign line_oe_o    = (state_q != IDLE);
  assign nrz_bit_o    = w_sending & w_nrz;
  assign half_o       = w_sending & w_half;
  assign line_out_o   = w_sending ? manchester_level(w_nrz, w_half) : IDLE_LEVEL;
  assign frame_done_o = (state_q == GAP) && w_bit_tick;

endmodule
`default_nettype wire
